// File: rtl/ddp_bram_clr_pkg.sv
// ddp_bram_clr_pkg: shared constants and clear-sequencer state encoding
package ddp_bram_clr_pkg;
    localparam int WMODE_READ_FIRST  = 0;
    localparam int WMODE_WRITE_FIRST = 1;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_e;
endpackage

// File: rtl/ddp_bram_clr_fsm.sv
// ddp_bram_clr_fsm: zero-clear sequencer, sweeps every address after reset or on request
module ddp_bram_clr_fsm
    import ddp_bram_clr_pkg::*;
#(
    parameter int LEN     = 256,
    parameter int LOG_LEN = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    output logic               busy,
    output logic               clr_we,
    output logic [LOG_LEN-1:0] clr_addr
);
    localparam logic [LOG_LEN-1:0] LAST = LOG_LEN'(LEN - 1);
    clr_state_e state, state_n;
    logic [LOG_LEN-1:0] cnt, cnt_n;
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end
    // unused encoding falls back to IDLE
    always_comb begin
        state_n  = (state == CLEAR) ? ((cnt == LAST) ? DONE : CLEAR) :
                   (state == IDLE && clr) ? CLEAR : IDLE;
        cnt_n    = (state == CLEAR) ? cnt + 1'b1 : '0;
        busy     = state != IDLE;
        clr_we   = state == CLEAR;
        clr_addr = cnt;
    end
endmodule

// File: rtl/ddp_bram_clr.sv
// ddp_bram_clr: true dual-port lane-masked block RAM with built-in zero-clear sweep
module ddp_bram_clr
    import ddp_bram_clr_pkg::*;
#(
    parameter int DWIDTH  = 16,
    parameter int LANE    = 8,
    parameter int LEN     = 256,
    parameter int LOG_LEN = 8,
    parameter int WMODE   = WMODE_READ_FIRST,
    parameter int OREG    = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    output logic                     busy,
    input  logic                     ena,
    input  logic                     enb,
    input  logic [DWIDTH/LANE-1:0]   wea,
    input  logic [DWIDTH/LANE-1:0]   web,
    input  logic [LOG_LEN-1:0]       addra,
    input  logic [LOG_LEN-1:0]       addrb,
    input  logic [DWIDTH-1:0]        dla,
    input  logic [DWIDTH-1:0]        dlb,
    output logic [DWIDTH-1:0]        doa,
    output logic [DWIDTH-1:0]        dob,
    output logic                     coll
);
    localparam int NLANE = DWIDTH / LANE;
    logic [DWIDTH-1:0] mem [LEN];
    logic clr_we, ina, inb, act_a, act_b, hit;
    logic [LOG_LEN-1:0] clr_addr;
    logic [NLANE-1:0] wa, wb;
    logic [DWIDTH-1:0] olda, oldb, rda, rdb, pa, pb;

    ddp_bram_clr_fsm #(.LEN(LEN), .LOG_LEN(LOG_LEN)) u_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // port A owns overlapping lanes; each port's read-back only merges its own write
    always_comb begin
        ina   = int'(addra) < LEN;
        inb   = int'(addrb) < LEN;
        act_a = ena && !busy;
        act_b = enb && !busy;
        hit   = addra == addrb;
        wa    = (act_a && ina) ? wea : '0;
        wb    = (act_b && inb) ? (web & ~(hit ? wa : '0)) : '0;
        olda  = ina ? mem[addra] : '0;
        oldb  = inb ? mem[addrb] : '0;
        rda   = olda;
        rdb   = oldb;
        for (int i = 0; i < NLANE; i++) begin
            rda[i*LANE +: LANE] = (WMODE == WMODE_WRITE_FIRST && wa[i]) ? dla[i*LANE +: LANE] : olda[i*LANE +: LANE];
            rdb[i*LANE +: LANE] = (WMODE == WMODE_WRITE_FIRST && wb[i]) ? dlb[i*LANE +: LANE] : oldb[i*LANE +: LANE];
        end
    end

    always_ff @(negedge clk) begin
        if (clr_we)
            mem[clr_addr] <= '0;
        for (int i = 0; i < NLANE; i++) begin
            if (wa[i])
                mem[addra][i*LANE +: LANE] <= dla[i*LANE +: LANE];
            if (wb[i])
                mem[addrb][i*LANE +: LANE] <= dlb[i*LANE +: LANE];
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pa   <= '0;
            pb   <= '0;
            doa  <= '0;
            dob  <= '0;
            coll <= 1'b0;
        end else begin
            if (act_a) begin
                pa  <= rda;
                doa <= (OREG != 0) ? pa : rda;
            end
            if (act_b) begin
                pb  <= rdb;
                dob <= (OREG != 0) ? pb : rdb;
            end
            coll <= act_a && act_b && hit && ina && |(wea & web);
        end
    end
endmodule

// File: tb/tb_ddp_bram_clr.sv
// tb_ddp_bram_clr: directed vectors for a read-first/no-OREG RAM and a write-first/OREG RAM with short LEN
module tb_ddp_bram_clr;
    logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
    logic ena = 1'b0, enb = 1'b0;
    logic [1:0] wea = '0, web = '0;
    logic [7:0] addra = '0, addrb = '0;
    logic [15:0] dla = '0, dlb = '0;
    logic busy0, busy1, coll0, coll1;
    logic [15:0] doa0, dob0, doa1, dob1;
    int errors = 0, checks = 0;
    int n0, n1;

    always #5 clk = ~clk;

    ddp_bram_clr u0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy0),
        .ena(ena), .enb(enb), .wea(wea), .web(web),
        .addra(addra), .addrb(addrb), .dla(dla), .dlb(dlb),
        .doa(doa0), .dob(dob0), .coll(coll0)
    );

    ddp_bram_clr #(.LEN(200), .WMODE(1), .OREG(1)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy1),
        .ena(ena), .enb(enb), .wea(wea), .web(web),
        .addra(addra), .addrb(addrb), .dla(dla), .dlb(dlb),
        .doa(doa1), .dob(dob1), .coll(coll1)
    );

    typedef struct {
        logic ea; logic [1:0] wa; logic [7:0] aa; logic [15:0] da;
        logic eb; logic [1:0] wb; logic [7:0] ab; logic [15:0] db;
        logic [15:0] xa, xb; logic xc;
    } vec_t;
    vec_t tv [16];

    task automatic step();
        @(negedge clk);
        @(posedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic port(input logic ea, input logic [1:0] wa, input logic [7:0] aa, input logic [15:0] da,
                        input logic eb, input logic [1:0] wb, input logic [7:0] ab, input logic [15:0] db);
        ena = ea; wea = wa; addra = aa; dla = da;
        enb = eb; web = wb; addrb = ab; dlb = db;
    endtask

    // counts busy cycles of both instances; optionally hammers colliding writes while busy
    task automatic count_busy(input logic hammer, output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        for (int k = 0; k < 1000 && (busy0 || busy1); k++) begin
            if (busy0) c0++;
            if (busy1) c1++;
            if (hammer && k > 0) chk("coll_busy", {31'd0, coll0}, 0);
            if (hammer && k < 150) port(1, 2'b11, 8'd7, 16'h5555, 1, 2'b11, 8'd7, 16'h3333);
            else port(0, 2'b00, 8'd0, 16'h0, 0, 2'b00, 8'd0, 16'h0);
            step();
        end
        port(0, 2'b00, 8'd0, 16'h0, 0, 2'b00, 8'd0, 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tv[0]  = '{1, 2'b00, 8'd0,   16'h0000, 1, 2'b00, 8'd128, 16'h0000, 16'h0000, 16'h0000, 0};
        tv[1]  = '{1, 2'b00, 8'd255, 16'h0000, 1, 2'b00, 8'd0,   16'h0000, 16'h0000, 16'h0000, 0};
        tv[2]  = '{1, 2'b11, 8'd5,   16'hBEEF, 0, 2'b00, 8'd0,   16'h0000, 16'h0000, 16'h0000, 0};
        tv[3]  = '{1, 2'b10, 8'd5,   16'h1200, 1, 2'b00, 8'd5,   16'h0000, 16'hBEEF, 16'hBEEF, 0};
        tv[4]  = '{1, 2'b00, 8'd5,   16'h0000, 0, 2'b00, 8'd0,   16'h0000, 16'h12EF, 16'hBEEF, 0};
        tv[5]  = '{1, 2'b11, 8'd9,   16'hAAAA, 1, 2'b00, 8'd7,   16'h0000, 16'h0000, 16'h0000, 0};
        tv[6]  = '{1, 2'b00, 8'd9,   16'h0000, 1, 2'b01, 8'd9,   16'h5555, 16'hAAAA, 16'hAAAA, 0};
        tv[7]  = '{1, 2'b00, 8'd9,   16'h0000, 0, 2'b00, 8'd0,   16'h0000, 16'hAA55, 16'hAAAA, 0};
        tv[8]  = '{1, 2'b11, 8'd3,   16'h1111, 1, 2'b01, 8'd3,   16'h2222, 16'h0000, 16'h0000, 1};
        tv[9]  = '{1, 2'b00, 8'd3,   16'h0000, 1, 2'b00, 8'd3,   16'h0000, 16'h1111, 16'h1111, 0};
        tv[10] = '{1, 2'b01, 8'd4,   16'h00AB, 1, 2'b10, 8'd4,   16'hCD00, 16'h0000, 16'h0000, 0};
        tv[11] = '{1, 2'b00, 8'd4,   16'h0000, 0, 2'b00, 8'd0,   16'h0000, 16'hCDAB, 16'h0000, 0};
        tv[12] = '{1, 2'b10, 8'd6,   16'h1234, 1, 2'b11, 8'd6,   16'h5678, 16'h0000, 16'h0000, 1};
        tv[13] = '{0, 2'b00, 8'd0,   16'h0000, 1, 2'b00, 8'd6,   16'h0000, 16'h0000, 16'h1278, 0};
        tv[14] = '{1, 2'b00, 8'd5,   16'hFFFF, 1, 2'b00, 8'd5,   16'h0000, 16'h12EF, 16'h12EF, 0};
        tv[15] = '{0, 2'b11, 8'd5,   16'h0000, 1, 2'b00, 8'd5,   16'h0000, 16'h12EF, 16'h12EF, 0};

        // reset and power-up sweep
        step();
        step();
        chk("rst_busy0", {31'd0, busy0}, 1);
        chk("rst_busy1", {31'd0, busy1}, 1);
        chk("rst_doa", {16'd0, doa0}, 0);
        chk("rst_dob", {16'd0, dob0}, 0);
        chk("rst_coll", {31'd0, coll0}, 0);
        rst_n = 1'b1;
        count_busy(0, n0, n1);
        chk("rst_len0", n0, 257);
        chk("rst_len1", n1, 201);
        chk("post_rst_doa", {16'd0, doa0}, 0);

        for (int i = 0; i < 16; i++) begin
            port(tv[i].ea, tv[i].wa, tv[i].aa, tv[i].da, tv[i].eb, tv[i].wb, tv[i].ab, tv[i].db);
            step();
            chk($sformatf("v%0d_doa", i), {16'd0, doa0}, {16'd0, tv[i].xa});
            chk($sformatf("v%0d_dob", i), {16'd0, dob0}, {16'd0, tv[i].xb});
            chk($sformatf("v%0d_coll", i), {31'd0, coll0}, {31'd0, tv[i].xc});
        end

        // write-first merge and two-stage latency on u1
        port(1, 2'b11, 8'd20, 16'h0F0F, 0, 2'b00, 8'd0, 16'h0);
        step();
        chk("rf_old", {16'd0, doa0}, 0);
        port(1, 2'b01, 8'd20, 16'hA0A0, 0, 2'b00, 8'd0, 16'h0);
        step();
        chk("rf_prev", {16'd0, doa0}, 16'h0F0F);
        chk("wf_lat2", {16'd0, doa1}, 16'h0F0F);
        port(1, 2'b00, 8'd20, 16'h0, 0, 2'b00, 8'd0, 16'h0);
        step();
        chk("rf_merged", {16'd0, doa0}, 16'h0FA0);
        chk("wf_merged", {16'd0, doa1}, 16'h0FA0);
        port(0, 2'b00, 8'd20, 16'h0, 0, 2'b00, 8'd0, 16'h0);
        step();
        chk("oreg_hold", {16'd0, doa1}, 16'h0FA0);

        // out-of-range on the LEN=200 instance
        port(1, 2'b11, 8'd210, 16'h1234, 0, 2'b00, 8'd0, 16'h0);
        step();
        port(1, 2'b00, 8'd210, 16'h0, 0, 2'b00, 8'd0, 16'h0);
        step();
        chk("inrange_rd", {16'd0, doa0}, 16'h1234);
        step();
        chk("oor_rd", {16'd0, doa1}, 0);

        // fill with ones, then clear on request
        for (int i = 0; i < 128; i++) begin
            port(1, 2'b11, 8'(2*i), 16'hFFFF, 1, 2'b11, 8'(2*i+1), 16'hFFFF);
            step();
        end
        port(1, 2'b00, 8'd5, 16'h0, 0, 2'b00, 8'd0, 16'h0);
        step();
        step();
        chk("fill_doa0", {16'd0, doa0}, 16'hFFFF);
        chk("fill_doa1", {16'd0, doa1}, 16'hFFFF);
        port(0, 2'b00, 8'd0, 16'h0, 0, 2'b00, 8'd0, 16'h0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_busy", {31'd0, busy0}, 1);
        count_busy(1, n0, n1);
        chk("clr_len0", n0, 257);
        chk("clr_len1", n1, 201);
        chk("clr_hold0", {16'd0, doa0}, 16'hFFFF);
        chk("clr_hold1", {16'd0, doa1}, 16'hFFFF);
        for (int i = 0; i < 256; i++) begin
            port(1, 2'b00, 8'(i), 16'h0, 1, 2'b00, 8'(255-i), 16'h0);
            step();
            chk($sformatf("z%0d_a", i), {16'd0, doa0}, 0);
            chk($sformatf("z%0d_b", i), {16'd0, dob0}, 0);
            chk($sformatf("z%0d_oreg", i), {16'd0, doa1}, (i == 0) ? 32'hFFFF : 32'h0);
        end

        // reset in the middle of a clear sweep
        port(1, 2'b11, 8'd1, 16'hABCD, 0, 2'b00, 8'd0, 16'h0);
        step();
        port(1, 2'b00, 8'd1, 16'h0, 0, 2'b00, 8'd0, 16'h0);
        step();
        step();
        chk("pre_doa0", {16'd0, doa0}, 16'hABCD);
        chk("pre_doa1", {16'd0, doa1}, 16'hABCD);
        port(0, 2'b00, 8'd0, 16'h0, 0, 2'b00, 8'd0, 16'h0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (100) step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_doa0", {16'd0, doa0}, 0);
        chk("mid_rst_doa1", {16'd0, doa1}, 0);
        chk("mid_rst_busy", {31'd0, busy0}, 1);
        rst_n = 1'b1;
        count_busy(0, n0, n1);
        chk("mid_len0", n0, 257);
        chk("mid_len1", n1, 201);
        port(1, 2'b00, 8'd1, 16'h0, 1, 2'b00, 8'd199, 16'h0);
        step();
        step();
        chk("mid_rd_a", {16'd0, doa0}, 0);
        chk("mid_rd_b", {16'd0, dob0}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
